// File: rtl/alu_serial.sv
// Nibble-serial ALU: computes one 4-bit slice of a WIDTH-bit add/sub/logic/shift per cycle.
// Requests and results use a valid/ready handshake, and only one operation is in flight at a time.
module alu_serial #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [4:0]       cmd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             carry_out,
  output logic             zero,
  output logic             ones
);

  localparam int unsigned NIB   = WIDTH / 4;
  localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("alu_serial: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Captured request; b holds the operand already conditionally inverted by cmd[3].
  typedef struct packed {
    logic [4:0]       cmd;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] a;
  } req_t;

  state_t           state, state_nxt;
  req_t             req_q;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic             accept;
  logic             last;

  logic [3:0]       a_nib, b_nib, sh_nib, nib_res;
  logic [4:0]       sum;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] res_nxt;
  logic             co_nxt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake decode
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (idx_q == IDX_W'(NIB - 1)) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Current nibble slice and its result
  always_comb begin
    shifted = {req_q.cmd[4], req_q.b[WIDTH-1:1]};
    a_nib   = 4'(req_q.a >> {idx_q, 2'b00});
    b_nib   = 4'(req_q.b >> {idx_q, 2'b00});
    sh_nib  = 4'(shifted >> {idx_q, 2'b00});
    sum     = {1'b0, a_nib} + {1'b0, b_nib} + 5'(carry_q);
    nib_res = 4'h0;
    co_nxt  = 1'b0;
    case (req_q.cmd[1:0])
      2'b00: begin
        if (req_q.cmd[2]) begin
          nib_res = a_nib ^ b_nib;
        end else begin
          nib_res = sum[3:0];
          co_nxt  = sum[4];
        end
      end
      2'b01: nib_res = a_nib & b_nib;
      2'b10: nib_res = a_nib | b_nib;
      2'b11: begin
        nib_res = sh_nib;
        co_nxt  = req_q.b[0];
      end
      default: nib_res = 4'h0;
    endcase
    res_nxt = res;
    for (int n = 0; n < NIB; n++) begin
      if (idx_q == IDX_W'(n)) res_nxt[4*n +: 4] = nib_res;
    end
  end

  // Request capture, nibble sequencing and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q     <= '0;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      res       <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
      ones      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      if (accept) begin
        req_q.a   <= d1;
        req_q.b   <= d2 ^ {WIDTH{cmd[3]}};
        req_q.cmd <= cmd;
        idx_q     <= '0;
        carry_q   <= cmd[4];
      end else if (state == RUN) begin
        res     <= res_nxt;
        carry_q <= sum[4];
        idx_q   <= idx_q + IDX_W'(1);
        if (last) begin
          carry_out <= co_nxt;
          zero      <= (res_nxt == '0);
          ones      <= (res_nxt == '1);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_serial.sv
// Scoreboard bench for alu_serial (WIDTH=16): directed vectors, backpressure, reset abort, random ops.
module tb_alu_serial;

  localparam int unsigned W   = 16;
  localparam int unsigned NIB = W / 4;

  typedef struct packed {
    logic [W-1:0] res;
    logic         co;
    logic         z;
    logic         o;
  } exp_t;

  logic         clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] d1, d2, res;
  logic [4:0]   cmd;
  logic         carry_out, zero, ones;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;

  alu_serial #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .d1(d1), .d2(d2), .cmd(cmd), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .carry_out(carry_out), .zero(zero), .ones(ones)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full-width reference computation
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] db, input logic [4:0] c);
    exp_t         e;
    logic [W-1:0] b;
    logic [W:0]   s;
    b    = db ^ {W{c[3]}};
    e.co = 1'b0;
    case (c[1:0])
      2'b00: begin
        if (c[2]) e.res = a ^ b;
        else begin
          s     = {1'b0, a} + {1'b0, b} + (W+1)'(c[4]);
          e.res = s[W-1:0];
          e.co  = s[W];
        end
      end
      2'b01: e.res = a & b;
      2'b10: e.res = a | b;
      default: begin
        e.res = {c[4], b[W-1:1]};
        e.co  = b[0];
      end
    endcase
    e.z = (e.res == '0);
    e.o = (e.res == '1);
    return e;
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] c, input exp_t e);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    in_valid = 1'b1; d1 = a; d2 = b; cmd = c;
    exp_q.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic collect(input int stall);
    int   lat;
    exp_t e, got;
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    vectors++;
    if (lat !== NIB) begin
      miscompares++;
      $display("FAIL latency: got %0d cycles, expected %0d", lat, NIB);
    end
    e = exp_q.pop_front();
    if (!out_valid) return;
    got = {res, carry_out, zero, ones};
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL result cmd=%b d1=%h d2=%h: got res=%h co=%b z=%b o=%b, expected res=%h co=%b z=%b o=%b",
               cmd, d1, d2, got.res, got.co, got.z, got.o, e.res, e.co, e.z, e.o);
    end
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      vectors++;
      if ({out_valid, in_ready, res, carry_out, zero, ones} !== {1'b1, 1'b0, e}) begin
        miscompares++;
        $display("FAIL hold[%0d]: got ov=%b ir=%b res=%h, expected ov=1 ir=0 res=%h", k, out_valid, in_ready, res, e.res);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vectors++;
    if ({out_valid, in_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL transfer: got ov=%b ir=%b, expected ov=0 ir=1", out_valid, in_ready);
    end
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] c, input exp_t e, input int stall);
    issue(a, b, c, e);
    collect(stall);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; d1 = '0; d2 = '0; cmd = '0;
    #12;
    vectors++;
    if ({in_ready, out_valid, res, carry_out, zero, ones} !== {1'b1, 1'b0, {W{1'b0}}, 3'b000}) begin
      miscompares++;
      $display("FAIL reset: got ir=%b ov=%b res=%h co=%b z=%b o=%b", in_ready, out_valid, res, carry_out, zero, ones);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_arith;
    run(16'hFFFF, 16'h0001, 5'b00000, '{16'h0000, 1'b1, 1'b1, 1'b0}, 0);
    run(16'h1234, 16'h1235, 5'b11000, '{16'hFFFF, 1'b0, 1'b0, 1'b1}, 0);
    run(16'h1235, 16'h1234, 5'b11000, '{16'h0001, 1'b1, 1'b0, 1'b0}, 0);
    run(16'h8000, 16'h7FFF, 5'b01000, '{16'h0000, 1'b1, 1'b1, 1'b0}, 0);
    run(16'h5A5A, 16'h5A5A, 5'b01000, '{16'hFFFF, 1'b0, 1'b0, 1'b1}, 0);
    run(16'h0FFF, 16'h0001, 5'b00000, '{16'h1000, 1'b0, 1'b0, 1'b0}, 0);
  endtask

  task automatic test_logic;
    run(16'h1234, 16'h0003, 5'b10111, '{16'h8001, 1'b1, 1'b0, 1'b0}, 0);
    run(16'hF0F0, 16'hFF00, 5'b00101, '{16'hF000, 1'b0, 1'b0, 1'b0}, 0);
    run(16'h0000, 16'h00FF, 5'b01100, '{16'hFF00, 1'b0, 1'b0, 1'b0}, 0);
    run(16'h00F0, 16'h0F00, 5'b00110, '{16'h0FF0, 1'b0, 1'b0, 1'b0}, 0);
    run(16'hAAAA, 16'hAAAA, 5'b10100, '{16'h0000, 1'b0, 1'b1, 1'b0}, 0);
  endtask

  task automatic test_backpressure;
    issue(16'h0102, 16'h0304, 5'b00000, '{16'h0406, 1'b0, 1'b0, 1'b0});
    in_valid = 1'b1; d1 = 16'hFFFF; d2 = 16'hFFFF; cmd = 5'b00000;
    collect(3);
    in_valid = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({out_valid, in_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL ignored_req: got ov=%b ir=%b, expected ov=0 ir=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_abort;
    logic seen;
    issue(16'h1111, 16'h2222, 5'b00000, '{16'h3333, 1'b0, 1'b0, 1'b0});
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({out_valid, in_ready, res, carry_out, zero, ones} !== {1'b0, 1'b1, {W{1'b0}}, 3'b000}) begin
      miscompares++;
      $display("FAIL abort_reset: got ov=%b ir=%b res=%h co=%b z=%b o=%b", out_valid, in_ready, res, carry_out, zero, ones);
    end
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin @(posedge clk); #1; seen |= out_valid; end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_no_result: got out_valid=%b, expected 0", seen);
    end
    run(16'h7FFF, 16'h0001, 5'b00000, '{16'h8000, 1'b0, 1'b0, 1'b0}, 0);
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] a, b;
    logic [4:0]   c;
    for (int i = 0; i < 24; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      c = 5'($urandom);
      if (i % 6 == 0) b = a;
      run(a, b, c, model(a, b, c), int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_serial.md
ALU_SERIAL -- requirements
Module: alu_serial

Interface
REQ-001 Parameter WIDTH, default 16: operand/result width in bits; SHALL be a multiple of 4 and >= 4 (elaboration error otherwise).
REQ-002 Derived constant NIB = WIDTH/4: nibbles per operation.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block accepts a request this cycle.
REQ-007 d1  input  WIDTH  first operand.
REQ-008 d2  input  WIDTH  second operand.
REQ-009 cmd  input  5  command word: {carry_in, b_inv, carry_disable, op[1:0]}, same encoding as the 4-bit ALU command set (ADD 00000, SUB 11000, XOR x0100, XNOR x1100, COMP 01000, AND x0101, OR x0110, RSHFT x0111).
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 res  output  WIDTH  result.
REQ-013 carry_out  output  1  final carry / shifted-out bit.
REQ-014 zero  output  1  res == 0.
REQ-015 ones  output  1  res == all ones (A==B indicator for COMP).

Function
REQ-016 Handshake: request accepted on a rising edge with in_valid && in_ready; d1, d2, cmd SHALL be captured into internal registers at that edge.
REQ-017 Result transferred on a rising edge with out_valid && out_ready.
REQ-018 FSM states IDLE, RUN, DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-019 IDLE -> RUN on accept; nibble index cleared to 0; carry register loaded with cmd[4].
REQ-020 RUN: one nibble per cycle, LSB nibble first; index i computes res[4i+3:4i]; index increments; RUN -> DONE after index NIB-1.
REQ-021 Latency: out_valid SHALL rise exactly NIB cycles after the accepting edge (WIDTH=4: 1 cycle).
REQ-022 DONE -> IDLE on out_ready; res/carry_out/zero/ones SHALL hold stable while out_valid && !out_ready.
REQ-023 No pipelining: in_ready low from accept until the cycle after the output transfer; in_valid ignored outside IDLE.
REQ-024 Operand b' = d2 XOR {WIDTH{cmd[3]}} for every op.
REQ-025 op=00, carry_disable=0: nibble sum d1 + b' + carry, nibble carry-out registered as carry for nibble i+1; carry_out = carry from nibble NIB-1.
REQ-026 op=00, carry_disable=1: res = d1 XOR b'; carry_out = 0.
REQ-027 op=01: res = d1 AND b'; op=10: res = d1 OR b'; carry_disable ignored; carry_out = 0.
REQ-028 op=11 (RSHFT): res = {cmd[4], b'[WIDTH-1:1]}; d1 ignored; carry_out = b'[0].
REQ-029 All 32 cmd codes are legal; behaviour fully defined by REQ-024..028.
REQ-030 SUB: carry_out = 1 iff d1 >= d2 (unsigned); COMP (d1 - d2 - 1): carry_out = 1 iff d1 > d2, ones = 1 iff d1 == d2.
REQ-031 zero and ones computed on the full WIDTH result, valid whenever out_valid.
REQ-032 Arithmetic modulo 2^WIDTH; no overflow flag.

Reset
REQ-033 rst_n low SHALL force, asynchronously, state IDLE, index 0, carry 0, res 0, carry_out 0, zero 0, ones 0, out_valid 0, in_ready 1 (after release).
REQ-034 Reset asserted during RUN or DONE SHALL abort the operation; no result is delivered; first post-reset accept behaves as from power-up.

Verification (WIDTH=16 unless stated)
REQ-035 ADD d1=0xFFFF d2=0x0001 -> out_valid 4 cycles after accept, res 0x0000, carry_out 1, zero 1, ones 0.
REQ-036 SUB d1=0x1234 d2=0x1235 -> res 0xFFFF, carry_out 0, ones 1; SUB 0x1235-0x1234 -> res 0x0001, carry_out 1.
REQ-037 COMP d1=0x8000 d2=0x7FFF -> res 0x0000, carry_out 1; COMP d1=d2=0x5A5A -> res 0xFFFF, carry_out 0, ones 1.
REQ-038 RSHFT cmd=10111 d2=0x0003 -> res 0x8001, carry_out 1; AND d1=0xF0F0 d2=0xFF00 -> 0xF000; XNOR with d1=0 d2=0x00FF -> 0xFF00.
REQ-039 Backpressure: out_ready low 3 cycles after out_valid -> outputs stable, in_ready 0, new in_valid ignored; transfer then in_ready 1 next cycle.
REQ-040 rst_n pulsed low at RUN index 2 -> outputs zero immediately, no out_valid; WIDTH=4 and WIDTH=32 builds pass exhaustive/random ADD/SUB checks against reference model with latency NIB.
